// File: rtl/aes_key_schedule.sv
// Iterative AES-128 key expansion: emits round keys 0..10 one per accepted
// transfer on a valid/ready handshake. Includes the shared subByte S-box stage.

module subByte (
    input  logic [127:0] state,
    output logic [127:0] statebar
);
    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    for (genvar i = 0; i < 16; i++) begin : gByte
        assign statebar[8*i +: 8] = SBOX[state[8*i +: 8]];
    end
endmodule

module aes_key_schedule (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] key_in,
    input  logic         key_ready,
    output logic [127:0] round_key,
    output logic [3:0]   round_idx,
    output logic         key_valid,
    output logic         busy,
    output logic         done
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t       state_q, state_d;
    logic [127:0] round_key_q, round_key_d;
    logic [3:0]   round_idx_q, round_idx_d;
    logic         key_valid_q, key_valid_d;
    logic         done_q, done_d;

    logic [31:0]  w0, w1, w2, w3, rotWord, t;
    logic [31:0]  n0, n1, n2, n3;
    logic [127:0] sbOut;
    logic [95:0]  unused_sb;
    logic [3:0]   nextIdx;
    logic [7:0]   rcon;

    assign {w0, w1, w2, w3} = round_key_q;
    assign rotWord   = {w3[23:0], w3[31:24]};
    assign nextIdx   = round_idx_q + 4'd1;
    assign unused_sb = sbOut[95:0];

    subByte uSubWord (
        .state    ({rotWord, 96'h0}),
        .statebar (sbOut)
    );

    // rcon is selected by the index of the key being produced, not the current one
    always_comb begin
        rcon = 8'h00;
        case (nextIdx)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    assign t  = sbOut[127:96] ^ {rcon, 24'h0};
    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    always_comb begin
        state_d     = state_q;
        round_key_d = round_key_q;
        round_idx_d = round_idx_q;
        key_valid_d = key_valid_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    round_key_d = key_in;
                    round_idx_d = 4'd0;
                    key_valid_d = 1'b1;
                    state_d     = RUN;
                end
            end
            RUN: begin
                if (key_valid_q && key_ready) begin
                    if (round_idx_q == 4'd10) begin
                        key_valid_d = 1'b0;
                        done_d      = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        round_key_d = {n0, n1, n2, n3};
                        round_idx_d = nextIdx;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            round_key_q <= '0;
            round_idx_q <= '0;
            key_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            round_key_q <= round_key_d;
            round_idx_q <= round_idx_d;
            key_valid_q <= key_valid_d;
            done_q      <= done_d;
        end
    end

    assign round_key = round_key_q;
    assign round_idx = round_idx_q;
    assign key_valid = key_valid_q;
    assign busy      = (state_q == RUN);
    assign done      = done_q;
endmodule

// File: tb/tb_aes_key_schedule.sv
// Randomized bench for aes_key_schedule; expected round keys come from a
// GF(2^8)-arithmetic model of AES-128 key expansion.

module tb_aes_key_schedule;
    logic         clk = 1'b0;
    logic         reset, start, key_ready, key_valid, busy, done;
    logic [127:0] key_in, round_key;
    logic [3:0]   round_idx;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]   sboxM [256];
    logic [7:0]   rconM [11];
    logic [127:0] expKeys [11];

    always #5 clk = ~clk;

    aes_key_schedule dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .key_in    (key_in),
        .key_ready (key_ready),
        .round_key (round_key),
        .round_idx (round_idx),
        .key_valid (key_valid),
        .busy      (busy),
        .done      (done)
    );

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    // S-box built from the multiplicative inverse followed by the affine map
    task automatic buildTables();
        logic [7:0] inv, b, r;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(a), 8'(y)) == 8'h01) inv = 8'(y);
            b = inv;
            sboxM[a] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                       ^ {b[3:0], b[7:4]} ^ 8'h63;
        end
        r = 8'h01;
        rconM[0] = 8'h00;
        for (int i = 1; i < 11; i++) begin
            rconM[i] = r;
            r = gmul(r, 8'h02);
        end
    endtask

    task automatic computeSchedule(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] tmp;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sboxM[tmp[31:24]], sboxM[tmp[23:16]], sboxM[tmp[15:8]], sboxM[tmp[7:0]]}
                      ^ {rconM[i/4], 24'h0};
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int k = 0; k < 11; k++) expKeys[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [127:0] key);
        start  = 1'b1;
        key_in = key;
        tick();
        start  = 1'b0;
        key_in = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_key"},   round_key, 128'h0);
        checkOutput({tag, "_idx"},   {124'h0, round_idx}, 128'h0);
        checkOutput({tag, "_valid"}, {127'h0, key_valid}, 128'h0);
        checkOutput({tag, "_busy"},  {127'h0, busy}, 128'h0);
        checkOutput({tag, "_done"},  {127'h0, done}, 128'h0);
    endtask

    // Walks one expansion from round 0 to the done pulse; leaves the bench in the done cycle
    task automatic runExpansion(input logic [127:0] key, input int stallRound, input int stallLen,
                                input bit randReady, input bit junkStart);
        int expIdx = 0;
        int stalled = 0;
        int cycles = 0;
        bit finished = 0;
        computeSchedule(key);
        while (!finished && cycles < 200) begin
            checkOutput($sformatf("r%0d_key", expIdx), round_key, expKeys[expIdx]);
            checkOutput($sformatf("r%0d_idx", expIdx), {124'h0, round_idx}, 128'(expIdx));
            checkOutput("valid_hi", {127'h0, key_valid}, 128'h1);
            checkOutput("busy_hi",  {127'h0, busy}, 128'h1);
            checkOutput("done_lo",  {127'h0, done}, 128'h0);
            if (expIdx == stallRound && stalled < stallLen) begin
                key_ready = 1'b0;
                stalled++;
            end else if (randReady) begin
                key_ready = 1'($urandom_range(0, 1));
            end else begin
                key_ready = 1'b1;
            end
            start  = junkStart ? 1'($urandom_range(0, 1)) : 1'b0;
            key_in = {$urandom, $urandom, $urandom, $urandom};
            tick();
            if (key_ready) begin
                if (expIdx == 10) finished = 1;
                else expIdx++;
            end
            cycles++;
        end
        start = 1'b0;
        checkOutput("no_timeout", {127'h0, finished}, 128'h1);
        checkOutput("done_pulse", {127'h0, done}, 128'h1);
        checkOutput("done_valid", {127'h0, key_valid}, 128'h0);
        checkOutput("done_busy",  {127'h0, busy}, 128'h0);
        checkOutput("done_key",   round_key, expKeys[10]);
    endtask

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C1_KEY   = 128'h000102030405060708090a0b0c0d0e0f;

    initial begin
        reset = 1'b1; start = 1'b0; key_ready = 1'b0; key_in = '0;
        buildTables();
        tick();
        tick();
        checkIdle("rst");
        reset = 1'b0;
        tick();
        checkIdle("rst_hold");

        // Published vectors confirm the model itself
        computeSchedule(FIPS_KEY);
        checkOutput("fips_r1",  expKeys[1],  128'ha0fafe1788542cb123a339392a6c7605);
        checkOutput("fips_r2",  expKeys[2],  128'hf2c295f27a96b9435935807a7359f67f);
        checkOutput("fips_r10", expKeys[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        applyStimulus(FIPS_KEY);
        runExpansion(FIPS_KEY, -1, 0, 1'b0, 1'b0);
        tick();
        checkOutput("done_once", {127'h0, done}, 128'h0);
        checkOutput("keep_key",  round_key, expKeys[10]);

        // Stall at round 4 plus random start pulses that must be ignored
        applyStimulus(FIPS_KEY);
        runExpansion(FIPS_KEY, 4, 3, 1'b0, 1'b1);
        tick();

        // Reset at round 7 discards the sequence without a done pulse
        applyStimulus(FIPS_KEY);
        key_ready = 1'b1;
        repeat (7) tick();
        checkOutput("pre_rst_idx", {124'h0, round_idx}, 128'd7);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkIdle("mid_rst");
        tick();
        checkIdle("mid_rst2");

        // Reset beats start on the same edge
        reset = 1'b1; start = 1'b1; key_in = FIPS_KEY;
        tick();
        reset = 1'b0; start = 1'b0;
        checkIdle("rst_start");

        // Back-to-back: start issued in the done cycle
        applyStimulus(FIPS_KEY);
        runExpansion(FIPS_KEY, -1, 0, 1'b1, 1'b0);
        applyStimulus(C1_KEY);
        computeSchedule(C1_KEY);
        checkOutput("c1_r10_model", expKeys[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
        runExpansion(C1_KEY, -1, 0, 1'b0, 1'b0);

        // Random keys with random backpressure and stall points
        for (int n = 0; n < 6; n++) begin
            logic [127:0] rk;
            rk = {$urandom, $urandom, $urandom, $urandom};
            tick();
            applyStimulus(rk);
            runExpansion(rk, int'($urandom_range(0, 10)), int'($urandom_range(1, 4)), 1'b1, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
